// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register block.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        ACK_DEV,
        REG_ADDR,
        ACK_REG,
        WR_DATA,
        ACK_WR,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_t;

    localparam logic       I2C_ACK        = 1'b0;
    localparam logic       I2C_NACK       = 1'b1;
    localparam logic [6:0] DEF_SLAVE_ADDR = 7'h50;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus glitch filter for one I2C line.
// The filtered level changes only after FILT consecutive differing samples.
module i2c_line_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic filt,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] CNT_MAX = 4'(FILT - 1);

    logic [1:0] sync;
    logic [3:0] cnt;

    // Idle-high reset so an undriven bus never looks like a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            cnt  <= '0;
            filt <= 1'b1;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its source.
            sync <= {sync[0], line};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                filt <= sync[1];
                cnt  <= '0;
                rise <= sync[1];
                fall <= ~sync[1];
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with an 8 x 8-bit register file, pointer auto-increment and a fabric read port.
// Bus lines are oversampled on clk; sda is open-drain and only ever driven 0 or Z.
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter int         FILT       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [2:0] loc_addr,
    output logic [7:0] loc_rdata,
    output logic       wr_strobe,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic [2:0] ptr, ptr_n;
    logic       sda_out, sda_out_n;
    logic       busy_n;
    logic       wr_en;
    logic [7:0] byte_in;
    logic [7:0] regs [8];

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start, stop;

    i2c_line_filter #(.FILT(FILT)) u_scl_filt (
        .clk  (clk),
        .rst  (rst),
        .line (scl),
        .filt (scl_f),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_line_filter #(.FILT(FILT)) u_sda_filt (
        .clk  (clk),
        .rst  (rst),
        .line (sda),
        .filt (sda_f),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    assign start = sda_fall & scl_f;
    assign stop  = sda_rise & scl_f;
    assign sda   = sda_out ? 1'bz : 1'b0;

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        ptr_n     = ptr;
        sda_out_n = sda_out;
        busy_n    = busy;
        wr_en     = 1'b0;
        byte_in   = {shreg[6:0], sda_f};

        if (start) begin
            state_n   = DEV_ADDR;
            bit_cnt_n = '0;
            sda_out_n = 1'b1;
        end else if (stop) begin
            state_n   = IDLE;
            sda_out_n = 1'b1;
            busy_n    = 1'b0;
        end else begin
            case (state)
                DEV_ADDR, REG_ADDR, WR_DATA: begin
                    if (scl_rise) begin
                        shreg_n   = byte_in;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == DEV_ADDR) begin
                                if (byte_in[7:1] == SLAVE_ADDR) begin
                                    state_n = ACK_DEV;
                                    busy_n  = 1'b1;
                                end else begin
                                    state_n = IGNORE;
                                    busy_n  = 1'b0;
                                end
                            end else if (state == REG_ADDR) begin
                                ptr_n   = byte_in[2:0];
                                state_n = ACK_REG;
                            end else begin
                                wr_en   = 1'b1;
                                ptr_n   = ptr + 3'd1;
                                state_n = ACK_WR;
                            end
                        end
                    end
                end
                // First fall starts the ACK pulse, the second ends it and hands over.
                ACK_DEV, ACK_REG, ACK_WR: begin
                    if (scl_fall) begin
                        if (sda_out) begin
                            sda_out_n = I2C_ACK;
                        end else if (state == ACK_DEV && shreg[0]) begin
                            shreg_n   = regs[ptr];
                            sda_out_n = regs[ptr][7];
                            state_n   = RD_DATA;
                        end else begin
                            sda_out_n = 1'b1;
                            state_n   = (state == ACK_DEV) ? REG_ADDR : WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        sda_out_n = shreg[7];
                    end else if (scl_rise) begin
                        shreg_n   = {shreg[6:0], 1'b0};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ptr_n   = ptr + 3'd1;
                            state_n = RD_ACK;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_fall) begin
                        sda_out_n = 1'b1;
                    end else if (scl_rise) begin
                        if (sda_f == I2C_NACK) begin
                            state_n = IGNORE;
                            busy_n  = 1'b0;
                        end else begin
                            shreg_n = regs[ptr];
                            state_n = RD_DATA;
                        end
                    end
                end
                IDLE, IGNORE: begin
                    sda_out_n = 1'b1;
                end
                default: begin
                    state_n   = IDLE;
                    sda_out_n = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            sda_out   <= 1'b1;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            ptr       <= ptr_n;
            sda_out   <= sda_out_n;
            busy      <= busy_n;
            wr_strobe <= wr_en;
            if (wr_en) begin
                wr_addr <= ptr;
                wr_data <= byte_in;
            end
        end
    end

    // A same-cycle fabric read of the written address returns the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file is reset because its contents are bus-visible and must read 0.
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            loc_rdata <= '0;
        end else begin
            if (wr_en) regs[ptr] <= byte_in;
            loc_rdata <= regs[loc_addr];
        end
    end

endmodule
